oam_dma_ctrl: RTL and testbench

//  Sequences OAM sprite DMA: a CPU write of page P to TRIGGER_ADDR halts the CPU, then copies

---
 rtl/oam_dma_ctrl.sv | 119 +++++++++++
 tb/tb_oam_dma_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_ctrl.sv
// OAM sprite DMA sequencer: CPU write of a page to TRIGGER_ADDR halts the CPU and copies BYTE_COUNT bytes to OAMDATA.
// Latency: first OAM write 3 cycles after trigger (+1 on odd-cycle alignment); no backpressure, the CPU is simply halted.
module oam_dma_ctrl #(
  parameter logic [15:0] TRIGGER_ADDR = 16'h4014,
  parameter logic [2:0]  OAMDATA_REG  = 3'h4,
  parameter int          BYTE_COUNT   = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_halt,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic        ppu_grant,
  output logic [2:0]  ppu_address,
  output logic [7:0]  ppu_data,
  output logic        ppu_rw,
  output logic        ppu_cs,
  output logic        dma_done
);

  localparam logic [7:0] LAST_IDX = 8'(BYTE_COUNT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HALT  = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] page;
  logic [7:0] idx;
  logic       parity;
  logic       trigger;

  // Only honoured in IDLE, so a trigger coinciding with DONE or mid-transfer is dropped.
  assign trigger = (state == S_IDLE) && cpu_wr && (cpu_addr == TRIGGER_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity <= 1'b0;
      page   <= 8'h00;
      idx    <= 8'h00;
    end else begin
      parity <= ~parity;
      if (trigger) begin
        page <= cpu_wdata;
        idx  <= 8'h00;
      end else if (state == S_WRITE) begin
        idx <= idx + 8'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (trigger) state_nxt = S_HALT;
      S_HALT:  state_nxt = parity ? S_ALIGN : S_READ;
      S_ALIGN: state_nxt = S_READ;
      S_READ:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = (idx == LAST_IDX) ? S_DONE : S_READ;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_halt    = 1'b0;
    mem_rd      = 1'b0;
    mem_addr    = 16'h0000;
    ppu_grant   = 1'b0;
    ppu_cs      = 1'b1;
    ppu_rw      = 1'b0;
    ppu_address = 3'h0;
    ppu_data    = 8'h00;
    dma_done    = 1'b0;
    case (state)
      S_HALT, S_ALIGN: begin
        cpu_halt = 1'b1;
      end
      S_READ: begin
        cpu_halt  = 1'b1;
        ppu_grant = 1'b1;
        mem_rd    = 1'b1;
        mem_addr  = {page, idx};
      end
      S_WRITE: begin
        cpu_halt    = 1'b1;
        ppu_grant   = 1'b1;
        ppu_cs      = 1'b0;
        ppu_rw      = 1'b1;
        ppu_address = OAMDATA_REG;
        ppu_data    = mem_rdata;
      end
      S_DONE: begin
        dma_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Bench for oam_dma_ctrl: a full-size instance and a 4-byte instance share clock and reset.
// Stimulus queues expected OAM writes and completion records; a negedge monitor pops and compares.
module tb_oam_dma_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] cpu_addr_a = '0, cpu_addr_b = '0;
  logic        cpu_wr_a = 1'b0, cpu_wr_b = 1'b0;
  logic [7:0]  cpu_wdata_a = '0, cpu_wdata_b = '0;
  logic        cpu_halt_a, cpu_halt_b;
  logic [15:0] mem_addr_a, mem_addr_b;
  logic        mem_rd_a, mem_rd_b;
  logic [7:0]  mem_rdata_a = '0, mem_rdata_b = '0;
  logic        ppu_grant_a, ppu_grant_b;
  logic [2:0]  ppu_address_a, ppu_address_b;
  logic [7:0]  ppu_data_a, ppu_data_b;
  logic        ppu_rw_a, ppu_rw_b;
  logic        ppu_cs_a, ppu_cs_b;
  logic        dma_done_a, dma_done_b;

  oam_dma_ctrl dut_a (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr_a), .cpu_wr(cpu_wr_a), .cpu_wdata(cpu_wdata_a), .cpu_halt(cpu_halt_a),
    .mem_addr(mem_addr_a), .mem_rd(mem_rd_a), .mem_rdata(mem_rdata_a),
    .ppu_grant(ppu_grant_a), .ppu_address(ppu_address_a), .ppu_data(ppu_data_a),
    .ppu_rw(ppu_rw_a), .ppu_cs(ppu_cs_a), .dma_done(dma_done_a)
  );

  oam_dma_ctrl #(.BYTE_COUNT(4)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .cpu_addr(cpu_addr_b), .cpu_wr(cpu_wr_b), .cpu_wdata(cpu_wdata_b), .cpu_halt(cpu_halt_b),
    .mem_addr(mem_addr_b), .mem_rd(mem_rd_b), .mem_rdata(mem_rdata_b),
    .ppu_grant(ppu_grant_b), .ppu_address(ppu_address_b), .ppu_data(ppu_data_b),
    .ppu_rw(ppu_rw_b), .ppu_cs(ppu_cs_b), .dma_done(dma_done_b)
  );

  function automatic logic [7:0] ram_f(input logic [15:0] a);
    return (a[7:0] * 8'd7) ^ a[15:8] ^ 8'h3C;
  endfunction

  // RAM model: one-cycle read latency
  always @(posedge clk) begin
    if (mem_rd_a) mem_rdata_a <= ram_f(mem_addr_a);
    if (mem_rd_b) mem_rdata_b <= ram_f(mem_addr_b);
  end

  // Cycles since reset release; bit 0 equals the DUT's parity during that cycle.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int done_cyc;
    int halt_len;
  } done_rec_t;

  logic [15:0] wq[$];
  done_rec_t   dq[$];
  int          checks = 0;
  int          failures = 0;
  int          halt_cnt[2];
  int          wr_seen[2];
  logic [15:0] last_ma[2];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at cyc=%0d", nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input int id, input logic halt, input logic grant, input logic cs,
                     input logic rw, input logic mrd, input logic done, input logic [2:0] pa,
                     input logic [7:0] pd, input logic [15:0] ma);
    logic [15:0] e;
    done_rec_t   r;
    if (halt) halt_cnt[id]++;
    if (mrd) last_ma[id] = ma;
    if (!cs) begin
      if (wq.size() == 0) begin
        check("unexpected_write", {48'h0, ma}, 64'hFFFF_FFFF);
      end else begin
        e = wq.pop_front();
        check("wr_src_addr", {48'h0, last_ma[id]}, {48'h0, e});
        check("wr_data", {56'h0, pd}, {56'h0, ram_f(e)});
        check("wr_ctrl", {59'h0, grant, rw, pa}, {59'h0, 1'b1, 1'b1, 3'h4});
        wr_seen[id]++;
      end
    end
    if (done) begin
      if (dq.size() == 0) begin
        check("unexpected_done", 64'(cyc), 64'hFFFF_FFFF);
      end else begin
        r = dq.pop_front();
        check("done_cycle", 64'(cyc), 64'(r.done_cyc));
        check("halt_len", 64'(halt_cnt[id]), 64'(r.halt_len));
      end
      halt_cnt[id] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      halt_cnt[0] = 0;
      halt_cnt[1] = 0;
    end else begin
      mon(0, cpu_halt_a, ppu_grant_a, ppu_cs_a, ppu_rw_a, mem_rd_a, dma_done_a,
          ppu_address_a, ppu_data_a, mem_addr_a);
      mon(1, cpu_halt_b, ppu_grant_b, ppu_cs_b, ppu_rw_b, mem_rd_b, dma_done_b,
          ppu_address_b, ppu_data_b, mem_addr_b);
    end
  end

  task automatic check_idle(input string nm);
    check(nm, {31'h0, cpu_halt_a, mem_rd_a, mem_addr_a, ppu_grant_a, ppu_cs_a, ppu_rw_a,
               ppu_address_a, ppu_data_a, dma_done_a},
              {31'h0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 3'h0, 8'h00, 1'b0});
  endtask

  task automatic drive(input int id, input logic [15:0] a, input logic [7:0] d, input logic wr);
    if (id == 0) begin
      cpu_addr_a = a; cpu_wdata_a = d; cpu_wr_a = wr;
    end else begin
      cpu_addr_b = a; cpu_wdata_b = d; cpu_wr_b = wr;
    end
  endtask

  task automatic cpu_write(input int id, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    drive(id, a, d, 1'b1);
    @(negedge clk);
    drive(id, 16'h0000, 8'h00, 1'b0);
  endtask

  // align=1 picks a trigger cycle whose HALT cycle sees parity 1.
  task automatic start(input int id, input logic [7:0] page, input bit align, input int n,
                       input int push_n, input bit push_done, output int done_cyc);
    int want;
    done_rec_t r;
    want = align ? 0 : 1;
    @(negedge clk);
    while ((cyc % 2) != want) @(negedge clk);
    drive(id, 16'h4014, page, 1'b1);
    done_cyc = cyc + 2 + 2 * n + (align ? 1 : 0);
    for (int i = 0; i < push_n; i++) wq.push_back({page, 8'(i)});
    if (push_done) begin
      r.done_cyc = done_cyc;
      r.halt_len = 2 * n + 1 + (align ? 1 : 0);
      dq.push_back(r);
    end
    @(negedge clk);
    drive(id, 16'h0000, 8'h00, 1'b0);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((wq.size() != 0 || dq.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("drain", 64'(wq.size() + dq.size()), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int dc;
    int k;
    wr_seen[0] = 0;
    wr_seen[1] = 0;
    repeat (3) @(negedge clk);
    check_idle("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset_idle");

    // Non-trigger addresses must not start anything
    cpu_write(0, 16'h4015, 8'h02);
    check_idle("wr_4015_no_halt");
    cpu_write(0, 16'h2004, 8'h02);
    check_idle("wr_2004_no_halt");
    repeat (2) @(negedge clk);
    check_idle("no_dma_after_writes");

    // Unaligned full transfer from page 02
    start(0, 8'h02, 1'b0, 256, 256, 1'b1, dc);
    wait_drain(700);

    // Aligned transfer; retrigger and unrelated writes mid-transfer are ignored
    start(0, 8'h02, 1'b1, 256, 256, 1'b1, dc);
    repeat (20) @(negedge clk);
    cpu_write(0, 16'h4014, 8'h05);
    cpu_write(0, 16'h2004, 8'h99);
    k = 0;
    while (cyc < dc && k < 700) begin
      @(negedge clk);
      k++;
    end
    check("reach_done_cycle", 64'(cyc), 64'(dc));
    // Trigger presented during the DONE cycle is dropped
    drive(0, 16'h4014, 8'h07, 1'b1);
    @(negedge clk);
    drive(0, 16'h0000, 8'h00, 1'b0);
    check_idle("trigger_at_done_ignored");
    @(negedge clk);
    check_idle("still_idle_after_done");
    wait_drain(20);

    // Reset during byte 100
    wr_seen[0] = 0;
    start(0, 8'h02, 1'b0, 256, 100, 1'b0, dc);
    k = 0;
    while (wr_seen[0] < 100 && k < 400) begin
      @(negedge clk);
      #2;
      k++;
    end
    check("bytes_before_reset", 64'(wr_seen[0]), 64'd100);
    rst_n = 1'b0;
    #1;
    check_idle("mid_transfer_reset");
    check("queue_empty_at_reset", 64'(wq.size()), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle("idle_after_release");
    end

    // Fresh trigger after reset runs normally
    start(0, 8'h03, 1'b0, 256, 256, 1'b1, dc);
    wait_drain(700);

    // Short transfer from the last page
    start(1, 8'hFF, 1'b0, 4, 4, 1'b1, dc);
    wait_drain(40);
    check("short_xfer_bytes", 64'(wr_seen[1]), 64'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
